// File: rtl/coin_key_filter.sv
// Coin sensor debounce and pulse generator for the vending front end.
// Two independent channels (1-yuan, 0.5-yuan) each run a synchronizer,
// a press/release debounce FSM and a stable-count counter. A qualified
// press becomes a one-cycle pulse; when both qualify together the
// half-coin pulse is deferred by one cycle so the outputs never overlap.
module coin_key_filter #(
  parameter int              CNT_W   = 20,
  parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_one_n,
  input  logic key_half_n,
  input  logic accept_en,
  output logic pi_money_one,
  output logic pi_money_half,
  output logic coin_busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             qual;
  } ch_t;

  logic [1:0]       sync_one;
  logic [1:0]       sync_half;
  logic             key_s_one;
  logic             key_s_half;
  state_t           st_one;
  state_t           st_half;
  logic [CNT_W-1:0] cnt_one;
  logic [CNT_W-1:0] cnt_half;
  ch_t              nxt_one;
  ch_t              nxt_half;
  logic             pending;
  logic             take_one;
  logic             take_half;

  // One debounce step for a channel; the same transition rules serve both.
  function automatic ch_t step(input state_t st, input logic [CNT_W-1:0] cnt,
                               input logic key_s);
    ch_t r;
    r.st   = st;
    r.cnt  = cnt;
    r.qual = 1'b0;
    case (st)
      IDLE: begin
        if (!key_s) begin
          r.st  = PRESS_FILT;
          r.cnt = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          r.st  = IDLE;
          r.cnt = '0;
        end else if (cnt < CNT_MAX) begin
          r.cnt = cnt + CNT_W'(1);
        end else begin
          r.st   = DOWN;
          r.qual = 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          r.st  = REL_FILT;
          r.cnt = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          r.st  = DOWN;
          r.cnt = '0;
        end else if (cnt < CNT_MAX) begin
          r.cnt = cnt + CNT_W'(1);
        end else begin
          r.st  = IDLE;
          r.cnt = '0;
        end
      end
      default: begin
        r.st  = IDLE;
        r.cnt = '0;
      end
    endcase
    return r;
  endfunction

  // Two-flop synchronizers for the raw, idle-high sensor lines.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_one  <= '1;
      sync_half <= '1;
    end else begin
      sync_one  <= {sync_one[0], key_one_n};
      sync_half <= {sync_half[0], key_half_n};
    end
  end

  assign key_s_one  = sync_one[1];
  assign key_s_half = sync_half[1];

  // Next-state and counter logic for both channels.
  always_comb begin
    nxt_one  = step(st_one, cnt_one, key_s_one);
    nxt_half = step(st_half, cnt_half, key_s_half);
  end

  // Channel state and counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_one   <= IDLE;
      st_half  <= IDLE;
      cnt_one  <= '0;
      cnt_half <= '0;
    end else begin
      st_one   <= nxt_one.st;
      st_half  <= nxt_half.st;
      cnt_one  <= nxt_one.cnt;
      cnt_half <= nxt_half.cnt;
    end
  end

  assign take_one  = nxt_one.qual & accept_en;
  assign take_half = nxt_half.qual & accept_en;

  // Output pulses; a simultaneous half-coin is parked in pending for one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pi_money_one  <= 1'b0;
      pi_money_half <= 1'b0;
      pending       <= 1'b0;
      coin_busy     <= 1'b0;
    end else begin
      pi_money_one <= take_one;
      if (pending) begin
        pi_money_half <= 1'b1;
        pending       <= 1'b0;
      end else if (take_half && take_one) begin
        pi_money_half <= 1'b0;
        pending       <= 1'b1;
      end else begin
        pi_money_half <= take_half;
      end
      coin_busy <= (st_one != IDLE) || (st_half != IDLE) || pending;
    end
  end

endmodule
